// File: rtl/logits_top2_select.sv
// logits_top2_select
//   Captures a flat logits vector on a one-cycle strobe, scans it one class
//   per cycle to find the two largest signed logits (earliest index wins
//   ties), then offers the result on a valid/ready handshake.
//
// Ports
//   clk           single clock, rising edge
//   rst_n         asynchronous active-low reset
//   logits_in     flat logits, class i at [i*DATA_WIDTH +: DATA_WIDTH]
//   logits_valid  one-cycle strobe qualifying logits_in
//   busy          high whenever the block is not idle
//   top1_idx/val  index and value of the largest logit
//   top2_idx/val  index and value of the second-largest logit
//   result_valid  result qualifier, held until result_ready is sampled high
//   result_ready  consumer accept
//   dropped       sticky flag: a strobe arrived while busy
module logits_top2_select #(
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CLASSES = 1000,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_in,
  input  logic                              logits_valid,
  output logic                              busy,
  output logic [IDX_W-1:0]                  top1_idx,
  output logic [DATA_WIDTH-1:0]             top1_val,
  output logic [IDX_W-1:0]                  top2_idx,
  output logic [DATA_WIDTH-1:0]             top2_val,
  output logic                              result_valid,
  input  logic                              result_ready,
  output logic                              dropped
);

  // One extra counter bit so the terminal compare never wraps.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_CLASSES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    RESULT
  } state_e;

  state_e                            state_q;
  logic [DATA_WIDTH*NUM_CLASSES-1:0] logits_q;
  logic [CNT_W-1:0]                  cnt_q;
  logic                              top2_seen_q;
  logic [IDX_W-1:0]                  top1_idx_q;
  logic [DATA_WIDTH-1:0]             top1_val_q;
  logic [IDX_W-1:0]                  top2_idx_q;
  logic [DATA_WIDTH-1:0]             top2_val_q;
  logic                              result_valid_q;
  logic                              dropped_q;

  logic [IDX_W-1:0]      cur_idx;
  logic [DATA_WIDTH-1:0] cur_val;
  logic                  gt_top1;
  logic                  gt_top2;

  always_comb begin
    cur_idx = cnt_q[IDX_W-1:0];
    cur_val = logits_q[cur_idx*DATA_WIDTH +: DATA_WIDTH];
    // Strict compares: an equal value never displaces an earlier index.
    gt_top1 = $signed(cur_val) > $signed(top1_val_q);
    gt_top2 = $signed(cur_val) > $signed(top2_val_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      logits_q       <= '0;
      cnt_q          <= '0;
      top2_seen_q    <= 1'b0;
      top1_idx_q     <= '0;
      top1_val_q     <= '0;
      top2_idx_q     <= '0;
      top2_val_q     <= '0;
      result_valid_q <= 1'b0;
      dropped_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (logits_valid) begin
            logits_q    <= logits_in;
            cnt_q       <= '0;
            top2_seen_q <= 1'b0;
            state_q     <= SCAN;
          end
        end

        SCAN: begin
          if (logits_valid) begin
            dropped_q <= 1'b1;
          end
          if (cnt_q == '0) begin
            top1_idx_q <= cur_idx;
            top1_val_q <= cur_val;
          end else if (gt_top1) begin
            top2_idx_q  <= top1_idx_q;
            top2_val_q  <= top1_val_q;
            top1_idx_q  <= cur_idx;
            top1_val_q  <= cur_val;
            top2_seen_q <= 1'b1;
          end else if (!top2_seen_q || gt_top2) begin
            top2_idx_q  <= cur_idx;
            top2_val_q  <= cur_val;
            top2_seen_q <= 1'b1;
          end
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            result_valid_q <= 1'b1;
            state_q        <= RESULT;
          end
        end

        RESULT: begin
          if (logits_valid) begin
            dropped_q <= 1'b1;
          end
          if (result_ready) begin
            result_valid_q <= 1'b0;
            state_q        <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy         = (state_q != IDLE);
  assign top1_idx     = top1_idx_q;
  assign top1_val     = top1_val_q;
  assign top2_idx     = top2_idx_q;
  assign top2_val     = top2_val_q;
  assign result_valid = result_valid_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_logits_top2_select.sv
// Testbench for logits_top2_select with NUM_CLASSES=8, DATA_WIDTH=16.
// Expected results come from a whole-vector reference: top1 is the earliest
// maximum, top2 is the earliest maximum among the remaining classes.
module tb_logits_top2_select;

  localparam int DW = 16;
  localparam int NC = 8;
  localparam int IW = $clog2(NC);

  logic              clk;
  logic              rst_n;
  logic [DW*NC-1:0]  logits_in;
  logic              logits_valid;
  logic              busy;
  logic [IW-1:0]     top1_idx;
  logic [DW-1:0]     top1_val;
  logic [IW-1:0]     top2_idx;
  logic [DW-1:0]     top2_val;
  logic              result_valid;
  logic              result_ready;
  logic              dropped;

  logits_top2_select #(
    .DATA_WIDTH (DW),
    .NUM_CLASSES(NC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .logits_in   (logits_in),
    .logits_valid(logits_valid),
    .busy        (busy),
    .top1_idx    (top1_idx),
    .top1_val    (top1_val),
    .top2_idx    (top2_idx),
    .top2_val    (top2_val),
    .result_valid(result_valid),
    .result_ready(result_ready),
    .dropped     (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic signed [DW-1:0] vec [NC];
  int unsigned          e1_idx;
  int unsigned          e2_idx;
  logic [DW-1:0]        e1_val;
  logic [DW-1:0]        e2_val;

  int cyc;
  int busy_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-vector reference model.
  task automatic model();
    int b1;
    int b2;
    b1 = 0;
    for (int i = 1; i < NC; i++) begin
      if (vec[i] > vec[b1]) b1 = i;
    end
    b2 = -1;
    for (int i = 0; i < NC; i++) begin
      if (i != b1) begin
        if (b2 < 0) b2 = i;
        else if (vec[i] > vec[b2]) b2 = i;
      end
    end
    e1_idx = b1;
    e2_idx = b2;
    e1_val = vec[b1];
    e2_val = vec[b2];
  endtask

  // Ends on the falling edge right after the capture edge.
  task automatic capture();
    @(negedge clk);
    for (int i = 0; i < NC; i++) logits_in[i*DW +: DW] = vec[i];
    logits_valid = 1'b1;
    @(negedge clk);
    logits_valid = 1'b0;
  endtask

  // Counts falling edges until result_valid, bounded.
  task automatic wait_result();
    cyc = 0;
    busy_cnt = 0;
    while (result_valid !== 1'b1 && cyc < 50) begin
      if (busy === 1'b1) busy_cnt++;
      @(negedge clk);
      cyc++;
    end
    if (busy === 1'b1) busy_cnt++;
  endtask

  task automatic check_result(input string tag);
    model();
    chk({tag, "_valid"}, 64'(result_valid), 64'd1);
    chk({tag, "_top1_idx"}, 64'(top1_idx), 64'(e1_idx));
    chk({tag, "_top1_val"}, 64'(top1_val), 64'(e1_val));
    chk({tag, "_top2_idx"}, 64'(top2_idx), 64'(e2_idx));
    chk({tag, "_top2_val"}, 64'(top2_val), 64'(e2_val));
  endtask

  // Full transaction with result_ready held high.
  task automatic run_normal(input string tag);
    capture();
    wait_result();
    chk({tag, "_latency"}, 64'(cyc), 64'd8);
    check_result(tag);
    @(negedge clk);
    chk({tag, "_idle_after"}, 64'({busy, result_valid}), 64'd0);
  endtask

  logic [DW-1:0] r;

  initial begin
    rst_n        = 1'b0;
    logits_in    = '0;
    logits_valid = 1'b0;
    result_ready = 1'b1;
    for (int i = 0; i < NC; i++) vec[i] = '0;

    repeat (3) @(negedge clk);
    chk("reset_outputs",
        64'({busy, top1_idx, top1_val, top2_idx, top2_val, result_valid, dropped}), 64'd0);
    rst_n = 1'b1;

    // Distinct values, with latency and busy-duration checks.
    vec[0] = 16'sd5;   vec[1] = -16'sd3;   vec[2] = 16'sd100; vec[3] = 16'sd7;
    vec[4] = 16'sd99;  vec[5] = -16'sd200; vec[6] = 16'sd0;   vec[7] = 16'sd1;
    capture();
    wait_result();
    chk("distinct_latency", 64'(cyc), 64'd8);
    check_result("distinct");
    chk("distinct_top1_const", 64'({top1_idx, top1_val}), 64'({3'd2, 16'd100}));
    chk("distinct_top2_const", 64'({top2_idx, top2_val}), 64'({3'd4, 16'd99}));
    @(negedge clk);
    chk("distinct_busy_cycles", 64'(busy_cnt), 64'd9);
    chk("distinct_idle_after", 64'({busy, result_valid}), 64'd0);

    // All equal, most negative.
    for (int i = 0; i < NC; i++) vec[i] = 16'sh8000;
    run_normal("allneg");
    chk("allneg_const", 64'({top1_idx, top1_val, top2_idx, top2_val}),
        64'({3'd0, 16'h8000, 3'd1, 16'h8000}));

    // Tie with top1.
    vec[0] = 16'sd3; vec[1] = 16'sd9; vec[2] = 16'sd9; vec[3] = 16'sd1;
    vec[4] = 16'sd0; vec[5] = 16'sd0; vec[6] = 16'sd0; vec[7] = 16'sd9;
    run_normal("tie");
    chk("tie_const", 64'({top1_idx, top1_val, top2_idx, top2_val}),
        64'({3'd1, 16'd9, 3'd2, 16'd9}));

    // Randomized vectors; odd passes use a tiny range to force ties.
    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < NC; i++) begin
        if (n % 2 == 1) begin
          r = 16'($urandom_range(0, 3));
          vec[i] = r - 16'd1;
        end else begin
          vec[i] = 16'($urandom);
        end
      end
      run_normal("random");
    end

    // Backpressure: result held stable for 20 cycles.
    for (int i = 0; i < NC; i++) vec[i] = 16'($urandom);
    result_ready = 1'b0;
    capture();
    wait_result();
    chk("bp_latency", 64'(cyc), 64'd8);
    check_result("bp");
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_hold", 64'({result_valid, busy, top1_idx, top1_val, top2_idx, top2_val}),
          64'({1'b1, 1'b1, 3'(e1_idx), e1_val, 3'(e2_idx), e2_val}));
    end
    result_ready = 1'b1;
    @(negedge clk);
    chk("bp_release", 64'({busy, result_valid}), 64'd0);

    // Drops: one strobe during SCAN, one in RESULT together with ready.
    for (int i = 0; i < NC; i++) vec[i] = 16'($urandom);
    result_ready = 1'b0;
    capture();
    repeat (2) @(negedge clk);
    for (int i = 0; i < NC; i++) logits_in[i*DW +: DW] = 16'($urandom);
    logits_valid = 1'b1;
    @(negedge clk);
    logits_valid = 1'b0;
    wait_result();
    check_result("drop");
    chk("drop_flag_scan", 64'(dropped), 64'd1);
    for (int i = 0; i < NC; i++) logits_in[i*DW +: DW] = 16'($urandom);
    logits_valid = 1'b1;
    result_ready = 1'b1;
    @(negedge clk);
    logits_valid = 1'b0;
    chk("drop_result_idle", 64'({busy, result_valid, dropped}), 64'b001);
    for (int i = 0; i < NC; i++) vec[i] = 16'($urandom);
    run_normal("after_drop");
    chk("drop_sticky", 64'(dropped), 64'd1);

    // Asynchronous reset mid-scan at counter 4.
    for (int i = 0; i < NC; i++) vec[i] = 16'($urandom);
    capture();
    repeat (4) @(negedge clk);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midscan_reset",
        64'({busy, top1_idx, top1_val, top2_idx, top2_val, result_valid, dropped}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("post_reset_idle", 64'({busy, dropped}), 64'd0);
    for (int i = 0; i < NC; i++) vec[i] = 16'($urandom);
    run_normal("after_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
